// File: rtl/fade_ramp_if.sv
// Interface for the fade_ramp sequencer: enable in, duty level/phase/strobe out.
// FADE_SINGLE_SHOT_EN adds the start/done handshake.
interface fade_ramp_if #(
    parameter int unsigned W = 11
);
    logic         enable;
    logic [W-1:0] pwm_value;
    logic [1:0]   phase;
    logic         step_strb;
`ifdef FADE_SINGLE_SHOT_EN
    logic         start;
    logic         done;

    modport master (output enable, output start,
                    input pwm_value, input phase, input step_strb, input done);
    modport slave  (input enable, input start,
                    output pwm_value, output phase, output step_strb, output done);
`else
    modport master (output enable,
                    input pwm_value, input phase, input step_strb);
    modport slave  (input enable,
                    output pwm_value, output phase, output step_strb);
`endif
endinterface

// File: rtl/fade_ramp.sv
// Trapezoidal duty-cycle sequencer feeding a pwm compare: RISE, HOLD_HI, FALL, HOLD_LO.
// FADE_SINGLE_SHOT_EN: idle in HOLD_LO until start, run one trapezoid, pulse done.
module fade_ramp #(
    parameter int unsigned PWM_INTERVAL = 1800,
    parameter int unsigned STEP_CYCLES  = 12000,
    parameter int unsigned STEP_SIZE    = 18,
    parameter int unsigned HOLD_TICKS   = 100
) (
    input logic       clk,
    input logic       rst,
    fade_ramp_if.slave bus
);
    localparam int unsigned MAX_LEVEL = PWM_INTERVAL - 1;
    localparam int unsigned W         = $clog2(PWM_INTERVAL);
    localparam int unsigned PW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned HW        = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int unsigned HOLD_LAST = (HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0;

    typedef enum logic [1:0] {
        RISE    = 2'd0,
        HOLD_HI = 2'd1,
        FALL    = 2'd2,
        HOLD_LO = 2'd3
    } phase_t;

`ifdef FADE_SINGLE_SHOT_EN
    localparam phase_t RESET_PHASE = HOLD_LO;
`else
    localparam phase_t RESET_PHASE = RISE;
`endif

    phase_t        r_state, w_state_nxt;
    logic [W-1:0]  r_level, w_level_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [HW-1:0] r_hold,  w_hold_nxt;
    logic          r_strb,  w_strb_nxt;
    logic [W:0]    w_sum;
    logic          w_run;
    logic          w_tick;
`ifdef FADE_SINGLE_SHOT_EN
    logic          r_done, w_done_nxt;

    // HOLD_LO is the idle state in single-shot mode; nothing advances there.
    assign w_run = (r_state != HOLD_LO);
`else
    assign w_run = 1'b1;
`endif

    assign w_tick = bus.enable && w_run && (r_presc == PW'(STEP_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RESET_PHASE;
            r_level <= '0;
            r_presc <= '0;
            r_hold  <= '0;
            r_strb  <= 1'b0;
`ifdef FADE_SINGLE_SHOT_EN
            r_done  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_presc <= w_presc_nxt;
            r_hold  <= w_hold_nxt;
            r_strb  <= w_strb_nxt;
`ifdef FADE_SINGLE_SHOT_EN
            r_done  <= w_done_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_presc_nxt = r_presc;
        w_hold_nxt  = r_hold;
        w_strb_nxt  = 1'b0;
        // One extra bit so level+STEP_SIZE cannot wrap before the clamp test.
        w_sum       = {1'b0, r_level} + (W + 1)'(STEP_SIZE);
`ifdef FADE_SINGLE_SHOT_EN
        w_done_nxt  = 1'b0;
        if (!w_run && bus.enable && bus.start) begin
            w_state_nxt = RISE;
            w_strb_nxt  = 1'b1;
        end
`endif

        if (bus.enable && w_run)
            w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;

        if (w_tick) begin
            w_strb_nxt = 1'b1;
            unique case (r_state)
                RISE: begin
                    if (w_sum >= (W + 1)'(MAX_LEVEL)) begin
                        w_level_nxt = W'(MAX_LEVEL);
                        w_state_nxt = (HOLD_TICKS == 0) ? FALL : HOLD_HI;
                    end else begin
                        w_level_nxt = w_sum[W-1:0];
                    end
                end
                HOLD_HI: begin
                    if (r_hold == HW'(HOLD_LAST)) begin
                        w_hold_nxt  = '0;
                        w_state_nxt = FALL;
                    end else begin
                        w_hold_nxt  = r_hold + 1'b1;
                    end
                end
                FALL: begin
                    if (r_level <= W'(STEP_SIZE)) begin
                        w_level_nxt = '0;
`ifdef FADE_SINGLE_SHOT_EN
                        w_state_nxt = HOLD_LO;
                        w_done_nxt  = 1'b1;
`else
                        w_state_nxt = (HOLD_TICKS == 0) ? RISE : HOLD_LO;
`endif
                    end else begin
                        w_level_nxt = r_level - W'(STEP_SIZE);
                    end
                end
                HOLD_LO: begin
                    if (r_hold == HW'(HOLD_LAST)) begin
                        w_hold_nxt  = '0;
                        w_state_nxt = RISE;
                    end else begin
                        w_hold_nxt  = r_hold + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.pwm_value = r_level;
    assign bus.phase     = r_state;
    assign bus.step_strb = r_strb;
`ifdef FADE_SINGLE_SHOT_EN
    assign bus.done      = r_done;
`endif
endmodule
